wb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone (pipelined, stall/ack) arbiter that shares the single unified memory slave between the CPU instruction-fetch port (M0) and the load/store port (M1).
- Grants whole bus cycles (CYC-based ownership) with round-robin tie-break.
- Tracks outstanding requests so acks are never routed to the wrong master.
- Runs a watchdog that terminates hung cycles with an error pulse.

---
 rtl/wb_arbiter2.sv | 125 ++++++++++++
 tb/tb_wb_arbiter2.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter: whole-cycle ownership with
// round-robin tie-break, outstanding-request tracking and a hung-cycle watchdog.
module wb_arbiter2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = 4,
   parameter int MAXOUT  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_m0_cyc,
   input  logic          i_m0_stb,
   input  logic          i_m0_we,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_data,
   input  logic [SW-1:0] i_m0_sel,
   output logic          o_m0_stall,
   output logic          o_m0_ack,
   output logic          o_m0_err,
   output logic [DW-1:0] o_m0_data,
   input  logic          i_m1_cyc,
   input  logic          i_m1_stb,
   input  logic          i_m1_we,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_data,
   input  logic [SW-1:0] i_m1_sel,
   output logic          o_m1_stall,
   output logic          o_m1_ack,
   output logic          o_m1_err,
   output logic [DW-1:0] o_m1_data,
   output logic          o_s_cyc,
   output logic          o_s_stb,
   output logic          o_s_we,
   output logic [AW-1:0] o_s_addr,
   output logic [DW-1:0] o_s_data,
   output logic [SW-1:0] o_s_sel,
   input  logic          i_s_stall,
   input  logic          i_s_ack,
   input  logic [DW-1:0] i_s_data
);
   localparam int CW = $clog2(MAXOUT + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state;
   logic          last;
   logic [CW-1:0] cnt;
   logic [WW-1:0] wdog;

   logic own0, own1, owning, owner_cyc, owner_stb, busy, full;
   logic timeout, issue, retire, fwd;

   assign own0      = (state == OWN0);
   assign own1      = (state == OWN1);
   assign owning    = own0 | own1;
   assign owner_cyc = own1 ? i_m1_cyc : i_m0_cyc;
   assign owner_stb = own1 ? i_m1_stb : i_m0_stb;
   assign busy      = (cnt != '0);
   assign full      = (cnt == CW'(MAXOUT));

   // An ack arriving on the final watchdog cycle still counts as progress.
   assign timeout = owning & busy & ~i_s_ack & (wdog == WW'(TIMEOUT - 1));

   assign o_s_cyc  = owning & owner_cyc & ~timeout;
   assign o_s_stb  = o_s_cyc & owner_stb & ~full;
   assign o_s_we   = own1 ? i_m1_we   : i_m0_we;
   assign o_s_addr = own1 ? i_m1_addr : i_m0_addr;
   assign o_s_data = own1 ? i_m1_data : i_m0_data;
   assign o_s_sel  = own1 ? i_m1_sel  : i_m0_sel;

   assign issue  = o_s_stb & ~i_s_stall;
   assign retire = i_s_ack & busy;
   // Acks for an owner that already dropped cyc are swallowed here.
   assign fwd    = retire & owner_cyc;

   assign o_m0_ack   = fwd & own0;
   assign o_m1_ack   = fwd & own1;
   assign o_m0_err   = timeout & own0;
   assign o_m1_err   = timeout & own1;
   assign o_m0_stall = own0 ? (i_s_stall | full | timeout) : i_m0_cyc;
   assign o_m1_stall = own1 ? (i_s_stall | full | timeout) : i_m1_cyc;
   assign o_m0_data  = i_s_data;
   assign o_m1_data  = i_s_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
         wdog  <= '0;
      end else begin
         cnt <= cnt + CW'(issue) - CW'(retire);
         if (!busy || i_s_ack)
            wdog <= '0;
         else
            wdog <= wdog + WW'(1);
         case (state)
            IDLE: begin
               if (i_m0_cyc && (!i_m1_cyc || last))
                  state <= OWN0;
               else if (i_m1_cyc)
                  state <= OWN1;
            end
            OWN0, OWN1: begin
               if (timeout) begin
                  state <= IDLE;
                  last  <= own1;
                  cnt   <= '0;
                  wdog  <= '0;
               end else if (!owner_cyc && !busy) begin
                  // Hand straight over to a waiting master without an idle cycle.
                  last <= own1;
                  if (own1)
                     state <= i_m0_cyc ? OWN0 : IDLE;
                  else
                     state <= i_m1_cyc ? OWN1 : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural ownership model.
module tb_wb_arbiter2;
   localparam int AW = 32, DW = 32, SW = 4, MAXOUT = 4, TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]    m_cyc, m_stb, m_we;
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wdat [2];
   logic [SW-1:0] m_sel  [2];
   logic [1:0]    stall, ack, err;
   logic [DW-1:0] rdat [2];
   logic          s_cyc, s_stb, s_we, s_stall, s_ack;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdat, s_rdat;
   logic [SW-1:0] s_sel;

   wb_arbiter2 #(.AW(AW), .DW(DW), .SW(SW), .MAXOUT(MAXOUT), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
      .i_m0_addr(m_addr[0]), .i_m0_data(m_wdat[0]), .i_m0_sel(m_sel[0]),
      .o_m0_stall(stall[0]), .o_m0_ack(ack[0]), .o_m0_err(err[0]), .o_m0_data(rdat[0]),
      .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
      .i_m1_addr(m_addr[1]), .i_m1_data(m_wdat[1]), .i_m1_sel(m_sel[1]),
      .o_m1_stall(stall[1]), .o_m1_ack(ack[1]), .o_m1_err(err[1]), .o_m1_data(rdat[1]),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
      .o_s_addr(s_addr), .o_s_data(s_wdat), .o_s_sel(s_sel),
      .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_rdat)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cnow = 0;
   int ack_cnt [2] = '{0, 0};

   typedef struct {int due; logic [AW-1:0] a;} pend_t;
   pend_t pend [$];
   int ack_lat = 1, stall_pct = 0, spur_pct = 0;
   bit mute = 1'b0;

   function automatic logic [DW-1:0] memval(logic [AW-1:0] a);
      return 32'hC0DE_0000 | (a >> 2);
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cnow);
      end
   endtask

   // Slave: every accepted request is acked ack_lat cycles later, in order.
   always @(negedge clk) begin : slave_accept
      pend_t e;
      if (o_ok_accept()) begin
         e.due = cnow + ack_lat;
         e.a   = s_addr;
         pend.push_back(e);
      end
   end

   function automatic bit o_ok_accept();
      return s_stb && !s_stall && !mute;
   endfunction

   task automatic tick();
      @(posedge clk);
      cnow++;
      #1;
      s_ack = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cnow) begin
         s_ack  = 1'b1;
         s_rdat = memval(pend[0].a);
         void'(pend.pop_front());
      end else if (int'($urandom_range(99)) < spur_pct) begin
         s_ack  = 1'b1;
         s_rdat = $urandom;
      end
      s_stall = (int'($urandom_range(99)) < stall_pct);
   endtask

   task automatic set_m(int m, bit c, bit s, bit w, logic [AW-1:0] a);
      m_cyc[m]  = c;
      m_stb[m]  = s;
      m_we[m]   = w;
      m_addr[m] = a;
      m_wdat[m] = $urandom;
      m_sel[m]  = SW'($urandom);
   endtask

   // Reference model: owner index (-1 none), last owner, issued-but-unacked
   // count and number of consecutive stalled cycles without progress.
   int own = -1, last_w = 1, outn = 0, idle = 0;

   always @(negedge clk) begin : compare
      logic [1:0] e_ack, e_err, e_stall;
      logic e_scyc, e_sstb;
      bit expired, room;
      int o, old;
      e_ack = 2'b00; e_err = 2'b00; e_stall = m_cyc;
      e_scyc = 1'b0; e_sstb = 1'b0; expired = 1'b0; room = 1'b1;
      o = own;
      if (!rst && own >= 0) begin
         expired    = (outn > 0) && !s_ack && (idle + 1 == TIMEOUT);
         room       = (outn < MAXOUT);
         e_scyc     = m_cyc[o] && !expired;
         e_sstb     = e_scyc && m_stb[o] && room;
         e_ack[o]   = s_ack && (outn > 0) && m_cyc[o];
         e_err[o]   = expired;
         e_stall[o] = s_stall || !room || expired;
      end
      chk("ctl", 64'({s_cyc, s_stb, ack, err, stall}),
                 64'({e_scyc, e_sstb, e_ack, e_err, e_stall}));
      chk("bcast", 64'({rdat[0], rdat[1]}), 64'({s_rdat, s_rdat}));
      if (e_scyc) begin
         chk("route", 64'({s_addr, s_wdat}), 64'({m_addr[o], m_wdat[o]}));
         chk("route_sel", 64'({s_sel, s_we}), 64'({m_sel[o], m_we[o]}));
      end
      ack_cnt[0] += int'(ack[0]);
      ack_cnt[1] += int'(ack[1]);

      if (rst) begin
         own = -1; last_w = 1; outn = 0; idle = 0;
      end else if (own < 0) begin
         if (m_cyc == 2'b11)  own = (last_w == 1) ? 0 : 1;
         else if (m_cyc[0])   own = 0;
         else if (m_cyc[1])   own = 1;
      end else if (expired) begin
         own = -1; last_w = o; outn = 0; idle = 0;
      end else begin
         old  = outn;
         outn = outn + int'(e_sstb && !s_stall) - int'(s_ack && old > 0);
         idle = (old == 0 || s_ack) ? 0 : idle + 1;
         if (!m_cyc[o] && old == 0) begin
            last_w = o;
            own = m_cyc[1-o] ? 1 - o : -1;
         end
      end
   end

   initial begin
      int a0, a1, issued, waited, got_err;
      bit saw_full, leak;
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0;
      for (int m = 0; m < 2; m++) begin
         m_addr[m] = '0; m_wdat[m] = '0; m_sel[m] = '0;
      end
      s_stall = 1'b0; s_ack = 1'b0; s_rdat = '0;

      repeat (2) tick();
      set_m(0, 1, 0, 0, 0);
      @(negedge clk);
      chk("rst_state", 64'({s_cyc, s_stb, ack, err, stall}), 64'(8'b0000_0001));
      tick(); rst = 1'b0; set_m(0, 0, 0, 0, 0);

      // M0 alone: read of 0x10
      tick(); set_m(0, 1, 1, 0, 32'h10);
      @(negedge clk); chk("m0_idle_stall", 64'({stall[0], s_stb}), 64'(2'b10));
      tick();
      @(negedge clk); chk("m0_grant", 64'({s_stb, s_addr}), 64'({1'b1, 32'h10}));
      tick(); set_m(0, 1, 0, 0, 32'h10);
      @(negedge clk); chk("m0_ack", 64'({ack, rdat[0]}), 64'({2'b01, 32'hC0DE_0004}));
      tick(); set_m(0, 0, 0, 0, 0);
      tick();

      // Tie after M0 last owned: M1 wins, then same-edge handover back to M0
      tick(); set_m(0, 1, 1, 0, 32'h20); set_m(1, 1, 1, 1, 32'h40);
      @(negedge clk); chk("tie_idle_stall", 64'(stall), 64'(2'b11));
      tick();
      @(negedge clk); chk("tie_rr_m1", 64'({s_stb, s_addr, stall}), 64'({1'b1, 32'h40, 2'b01}));
      tick(); set_m(1, 1, 0, 1, 32'h40);
      @(negedge clk); chk("m1_ack", 64'(ack), 64'(2'b10));
      tick(); set_m(1, 0, 0, 0, 0);
      @(negedge clk); chk("handover_wait", 64'({s_cyc, stall[0]}), 64'(2'b01));
      tick();
      @(negedge clk); chk("handover_m0", 64'({s_cyc, s_stb, s_addr, stall[0]}),
                                          64'({2'b11, 32'h20, 1'b0}));
      tick(); set_m(0, 1, 0, 0, 32'h20);
      tick(); set_m(0, 0, 0, 0, 0);
      tick();

      // M1 burst of 6 with slow acks: must hit the MAXOUT limit
      ack_lat = 4; a0 = ack_cnt[0]; a1 = ack_cnt[1]; saw_full = 0; issued = 0;
      tick(); set_m(1, 1, 1, 1, 32'h100);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk); #1;
         if (m_stb[1] && s_stb && !stall[1]) issued++;
         if (m_stb[1] && s_cyc && !s_stb && stall[1]) saw_full = 1;
         if (ack_cnt[1] - a1 >= 6) break;
         tick();
         if (issued >= 6) set_m(1, 1, 0, 1, 32'h100);
         else set_m(1, 1, 1, 1, 32'h100 + 32'(issued * 4));
      end
      chk("burst_acks", 64'({32'(ack_cnt[1] - a1), 32'(ack_cnt[0] - a0)}), 64'({32'd6, 32'd0}));
      chk("burst_full_stall", 64'(saw_full), 64'(1));
      tick(); set_m(1, 0, 0, 0, 0);
      tick();

      // M0 leaves with two acks outstanding while M1 waits
      tick(); set_m(0, 1, 1, 0, 32'h200);
      tick();
      tick(); set_m(0, 1, 1, 0, 32'h204);
      tick(); set_m(0, 0, 0, 0, 0); set_m(1, 1, 1, 0, 32'h300);
      a0 = ack_cnt[0]; a1 = ack_cnt[1]; waited = 0; leak = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall[1]) break;
         if (s_cyc) leak = 1;
         waited++;
         tick();
      end
      #1;
      chk("absorb_wait", 64'(waited), 64'(5));
      chk("absorb_acks", 64'({32'(ack_cnt[1] - a1), 32'(ack_cnt[0] - a0)}), 64'(0));
      chk("absorb_cyc_low", 64'(leak), 64'(0));
      tick(); set_m(1, 1, 0, 0, 32'h300);
      repeat (5) tick();
      set_m(1, 0, 0, 0, 0);
      tick(); tick();

      // Slave never acks: watchdog aborts M0's cycle
      mute = 1'b1; got_err = -1;
      tick(); set_m(0, 1, 1, 0, 32'h400);
      tick();
      tick(); set_m(0, 1, 0, 0, 32'h400);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (err[0]) begin
            got_err = k;
            chk("timeout_drop", 64'({s_cyc, ack}), 64'(0));
            break;
         end
         tick();
      end
      chk("timeout_cycle", 64'(got_err), 64'(8));
      tick();
      @(negedge clk); chk("after_err", 64'({err, s_cyc, stall[0]}), 64'(4'b0001));
      tick(); set_m(0, 0, 0, 0, 0); mute = 1'b0;
      tick(); tick();

      // Asynchronous reset mid-burst, then a fresh tie goes to M0
      ack_lat = 2;
      tick(); set_m(1, 1, 1, 1, 32'h500);
      repeat (3) tick();
      tick(); #2 rst = 1'b1; #1;
      chk("async_rst", 64'({s_cyc, s_stb, ack, err}), 64'(0));
      tick(); rst = 1'b0; set_m(1, 0, 0, 0, 0);
      for (int k = 0; k < 20 && pend.size() > 0; k++) tick();
      tick(); set_m(0, 1, 1, 0, 32'h600); set_m(1, 1, 1, 0, 32'h700);
      tick();
      @(negedge clk); chk("rst_tie_m0", 64'({s_stb, s_addr}), 64'({1'b1, 32'h600}));
      tick(); set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
      repeat (4) tick();

      // Randomized traffic
      stall_pct = 25; spur_pct = 4;
      for (int k = 0; k < 4000; k++) begin
         tick();
         if (k % 400 == 0) begin
            ack_lat = int'($urandom_range(4, 1));
            mute = ($urandom_range(3) == 0);
         end
         for (int m = 0; m < 2; m++) begin
            if (!m_cyc[m]) begin
               if ($urandom_range(99) < 30)
                  set_m(m, 1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
            end else if ($urandom_range(99) < 10) begin
               set_m(m, 0, 0, 0, 0);
            end else begin
               set_m(m, 1, 1'($urandom_range(1)), m_we[m] ^ ($urandom_range(9) == 0), $urandom);
            end
         end
         if ($urandom_range(999) == 0) begin
            #2 rst = 1'b1;
         end else begin
            rst = 1'b0;
         end
      end
      rst = 1'b0;
      tick();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
